// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg: micro-stage encodings, opcode/func constants and path codes for the 16-bit CPU sequencer
package micro_sequencer_pkg;
  localparam int WORD_SIZE_DEF = 16;
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } upc_t;
  typedef enum logic [2:0] {
    P_ALU_WB,
    P_LOAD,
    P_STORE,
    P_BRANCH,
    P_JUMP,
    P_LINK,
    P_HALT,
    P_NOP
  } path_t;
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;
  function automatic logic is_alu_func(input logic [5:0] f);
    return f < 6'd8;
  endfunction
endpackage

// File: rtl/micro_sequencer_decode.sv
// inst_class_decode: maps opcode/func to the micro-stage path the instruction follows
module inst_class_decode
  import micro_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  output path_t      path
);
  path_t r_path;
  always_comb
    r_path = is_alu_func(func)                ? P_ALU_WB :
             (func == FN_JPR || func == FN_WWD) ? P_JUMP   :
             func == FN_JRL                     ? P_LINK   :
             func == FN_HLT                     ? P_HALT   : P_NOP;
  always_comb
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: path = P_BRANCH;
      OP_ADI, OP_ORI, OP_LHI:         path = P_ALU_WB;
      OP_LWD:                         path = P_LOAD;
      OP_SWD:                         path = P_STORE;
      OP_JMP:                         path = P_JUMP;
      OP_JAL:                         path = P_LINK;
      OP_RTYPE:                       path = r_path;
      default:                        path = P_NOP;
    endcase
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: multi-cycle IF/ID/EX/MEM/WB control FSM with retired-instruction counter
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 mem_ready,
  output logic [2:0]           microPC,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 pc_write,
  output logic                 inst_done,
  output logic                 is_halted,
  output logic [WORD_SIZE-1:0] num_inst
);
  upc_t  state, next;
  path_t path;
  logic  retire, halt_now;
  inst_class_decode u_dec (
    .opcode(opcode),
    .func  (func),
    .path  (path)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state     <= S_IF;
      num_inst  <= '0;
      is_halted <= 1'b0;
    end else begin
      state    <= next;
      num_inst <= num_inst + WORD_SIZE'(inst_done);
      if (halt_now) is_halted <= 1'b1;
    end
  always_comb begin
    next     = S_IF;
    retire   = 1'b0;
    halt_now = 1'b0;
    case (state)
      S_IF: next = mem_ready ? S_ID : S_IF;
      S_ID: begin
        halt_now = path == P_HALT;
        retire   = path inside {P_JUMP, P_NOP};
        next     = halt_now ? S_HALT : path == P_LINK ? S_WB : retire ? S_IF : S_EX;
      end
      S_EX: begin
        retire = !(path inside {P_ALU_WB, P_LOAD, P_STORE});
        next   = path == P_ALU_WB ? S_WB : retire ? S_IF : S_MEM;
      end
      S_MEM: begin
        retire = mem_ready && path != P_LOAD;
        next   = !mem_ready ? S_MEM : path == P_LOAD ? S_WB : S_IF;
      end
      S_WB:    retire = 1'b1;
      S_HALT:  next = S_HALT;
      default: next = S_IF;
    endcase
  end
  assign microPC   = state;
  assign ir_write  = !reset && state == S_IF && mem_ready;
  assign mem_read  = !reset && (state == S_IF || (state == S_MEM && path == P_LOAD));
  assign mem_write = !reset && state == S_MEM && path == P_STORE;
  assign reg_write = !reset && state == S_WB;
  assign pc_write  = !reset && retire;
  assign inst_done = !reset && (retire || halt_now);
endmodule
